// File: rtl/irq_ctrl_rr_pkg.sv
// rtl/irq_ctrl_rr_pkg.sv - shared state encoding and one-hot index helper for irq_ctrl_rr
// Contents: state_t (one-hot FSM states), MAX_SRC, onehot_to_idx().
package irq_ctrl_pkg;

    localparam int MAX_SRC = 32;

    localparam logic [2:0] S_IDLE    = 3'b001;
    localparam logic [2:0] S_SERVICE = 3'b010;
    localparam logic [2:0] S_HOLDOFF = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_SERVICE = S_SERVICE,
        ST_HOLDOFF = S_HOLDOFF
    } state_t;

    // OR-reduction of the set bit positions; exact for one-hot input, 0 for all-zero.
    function automatic int onehot_to_idx(input logic [MAX_SRC-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_rr_if.sv
// rtl/irq_ctrl_rr_if.sv - request/grant bundle between host side and irq_ctrl_rr
// master: drives req, mask, rr_mode, done; observes ack, irq, irq_id, pending, timeout_err.
// slave : the controller, opposite directions.
interface irq_ctrl_rr_if #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] mask;
    logic               rr_mode;
    logic               done;
    logic [NUM_SRC-1:0] ack;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] pending;
    logic               timeout_err;

    modport master (
        output req, mask, rr_mode, done,
        input  ack, irq, irq_id, pending, timeout_err
    );

    modport slave (
        input  req, mask, rr_mode, done,
        output ack, irq, irq_id, pending, timeout_err
    );
endinterface

// File: rtl/irq_ctrl_rr_arbiter.sv
// rtl/irq_ctrl_rr_arbiter.sv - combinational fixed / round-robin winner selection
// Inputs : eligible (pending & mask), rr_ptr (scan start), rr_mode (0 fixed, 1 round-robin)
// Outputs: winner_idx (binary), winner_oh (one-hot), any (some source eligible)
module rr_arbiter
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               rr_mode,
    output logic [ID_W-1:0]    winner_idx,
    output logic [NUM_SRC-1:0] winner_oh,
    output logic               any
);

    localparam int DW = 2 * NUM_SRC;
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [ID_W-1:0] start;
    logic [DW-1:0]   dbl;
    logic [DW-1:0]   scan_mask;
    logic [DW-1:0]   masked;
    logic [DW-1:0]   first;

    // Scanning two concatenated copies from 'start' upward gives wrap-around
    // priority with a plain lowest-set-bit pick; the upper copy is never masked,
    // so any eligible source always produces a hit.
    always_comb begin
        start = rr_mode ? rr_ptr : '0;
        dbl   = {eligible, eligible};
        for (int i = 0; i < DW; i++) begin
            scan_mask[i] = (i >= int'(start));
        end
        masked     = dbl & scan_mask;
        first      = masked & ((~masked) + ONE);
        winner_oh  = first[NUM_SRC-1:0] | first[DW-1:NUM_SRC];
        winner_idx = ID_W'(onehot_to_idx(MAX_SRC'(winner_oh)));
        any        = |eligible;
    end

endmodule

// File: rtl/irq_ctrl_rr.sv
// rtl/irq_ctrl_rr.sv - interrupt controller: sticky pending, mask, fixed/RR grant, done handshake, timeout
// Ports: clk, reset_n (async active-low), bus (irq_ctrl_rr_if.slave):
//   req/mask/rr_mode/done in; ack/irq/irq_id/pending/timeout_err out (all registered).
module irq_ctrl_rr
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ID_W        = $clog2(NUM_SRC),
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    irq_ctrl_rr_if.slave bus
);

    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_SRC - 1);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               terr_q, terr_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] clr;

    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_SRC-1:0] win_oh;
    logic               win_any;

    assign eligible = pending_q & bus.mask;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arb (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr_q),
        .rr_mode    (bus.rr_mode),
        .winner_idx (win_idx),
        .winner_oh  (win_oh),
        .any        (win_any)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        terr_d   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        clr      = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    ack_d    = win_oh;
                    irq_d    = 1'b1;
                    irq_id_d = win_idx;
                    clr      = win_oh;
                    cnt_d    = '0;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // done takes precedence, so a coincident timeout is not reported.
                if (bus.done || (TO_EN && (cnt_q == TO_LAST))) begin
                    ack_d    = '0;
                    irq_d    = 1'b0;
                    rr_ptr_d = (irq_id_q == LAST_ID) ? '0 : irq_id_q + 1'b1;
                    terr_d   = ~bus.done;
                    state_d  = ST_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                ack_d    = '0;
                irq_d    = 1'b0;
                irq_id_d = '0;
                cnt_d    = '0;
            end
        endcase

        // A request arriving on the grant edge re-sets the bit being cleared.
        pending_d = (pending_q & ~clr) | bus.req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            ack_q     <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            terr_q    <= 1'b0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            terr_q    <= terr_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.irq         = irq_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.pending     = pending_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_irq_ctrl_rr.sv
// tb/tb_irq_ctrl_rr.sv - directed self-checking bench for irq_ctrl_rr (NUM_SRC=4, TIMEOUT_CYC=8)
module tb_irq_ctrl_rr;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   low;
    bit   ok;

    irq_ctrl_rr_if #(.NUM_SRC(N)) bus();

    irq_ctrl_rr #(
        .NUM_SRC     (N),
        .TIMEOUT_CYC (8),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts low samples, starting with the current one, until irq is seen.
    task automatic wait_irq(output int low_cnt, output bit seen);
        low_cnt = 1;
        seen    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.irq === 1'b1) begin
                seen = 1'b1;
                break;
            end
            low_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "stalled");
    end

    initial begin
        reset_n     = 1'b0;
        bus.req     = '0;
        bus.mask    = '0;
        bus.rr_mode = 1'b0;
        bus.done    = 1'b0;
        tick(); tick();
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_id", 32'(bus.irq_id), 0);
        check("rst_pend", 32'(bus.pending), 0);
        check("rst_terr", 32'(bus.timeout_err), 0);
        reset_n = 1'b1;
        tick();
        check("idle_irq", 32'(bus.irq), 0);

        // 1: fixed priority, two sources pending
        bus.mask = 4'b1111;
        bus.req  = 4'b1010;
        tick();
        bus.req = '0;
        check("t1_pend_set", 32'(bus.pending), 32'h0000_000a);
        check("t1_no_irq_yet", 32'(bus.irq), 0);
        tick();
        check("t1_irq", 32'(bus.irq), 1);
        check("t1_ack", 32'(bus.ack), 32'h0000_0002);
        check("t1_id", 32'(bus.irq_id), 1);
        check("t1_pend", 32'(bus.pending), 32'h0000_0008);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t1_rel_irq", 32'(bus.irq), 0);
        check("t1_rel_ack", 32'(bus.ack), 0);
        tick();
        check("t1_hold_irq", 32'(bus.irq), 0);
        tick();
        check("t1_irq2", 32'(bus.irq), 1);
        check("t1_ack2", 32'(bus.ack), 32'h0000_0008);
        check("t1_id2", 32'(bus.irq_id), 3);
        check("t1_pend2", 32'(bus.pending), 0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t1_rel2_irq", 32'(bus.irq), 0);
        tick();

        // 2: round-robin with all sources requesting
        bus.rr_mode = 1'b1;
        bus.req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_irq(low, ok);
            check($sformatf("t2_seen%0d", k), 32'(ok), 1);
            check($sformatf("t2_id%0d", k), 32'(bus.irq_id), 32'(k % 4));
            if (k > 0) check($sformatf("t2_gap%0d", k), 32'(low >= 2), 1);
            tick();
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check($sformatf("t2_rel%0d", k), 32'(bus.irq), 0);
        end
        reset_n     = 1'b0;
        bus.req     = '0;
        bus.rr_mode = 1'b0;
        tick();
        check("t2_rst_pend", 32'(bus.pending), 0);
        reset_n = 1'b1;

        // 3: masked source stays pending until unmasked
        bus.mask = 4'b0000;
        bus.req  = 4'b0100;
        tick();
        bus.req = '0;
        check("t3_pend", 32'(bus.pending), 32'h0000_0004);
        check("t3_noirq", 32'(bus.irq), 0);
        tick();
        check("t3_noirq2", 32'(bus.irq), 0);
        check("t3_pend2", 32'(bus.pending), 32'h0000_0004);
        bus.mask = 4'b0100;
        tick();
        check("t3_irq", 32'(bus.irq), 1);
        check("t3_id", 32'(bus.irq_id), 2);
        check("t3_ack", 32'(bus.ack), 32'h0000_0004);
        check("t3_pend_clr", 32'(bus.pending), 0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();

        // 4: timeout after exactly 8 SERVICE cycles
        bus.mask = 4'b1111;
        bus.req  = 4'b0001;
        tick();
        bus.req = '0;
        tick();
        check("t4_irq", 32'(bus.irq), 1);
        check("t4_id", 32'(bus.irq_id), 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("t4_hold%0d", i), 32'(bus.irq), 1);
            check($sformatf("t4_noterr%0d", i), 32'(bus.timeout_err), 0);
        end
        tick();
        check("t4_rel_irq", 32'(bus.irq), 0);
        check("t4_terr", 32'(bus.timeout_err), 1);
        check("t4_rel_ack", 32'(bus.ack), 0);
        tick();
        check("t4_terr_pulse", 32'(bus.timeout_err), 0);

        // 4b: done on the timeout cycle wins, no error pulse
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        tick();
        check("t4b_irq", 32'(bus.irq), 1);
        for (int i = 1; i < 8; i++) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t4b_rel_irq", 32'(bus.irq), 0);
        check("t4b_terr", 32'(bus.timeout_err), 0);
        tick();

        // 5: request held across its own grant edge
        bus.req = 4'b0010;
        tick();
        tick();
        check("t5_irq", 32'(bus.irq), 1);
        check("t5_id", 32'(bus.irq_id), 1);
        check("t5_pend_set_wins", 32'(bus.pending), 32'h0000_0002);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = '0;
        check("t5_rel_irq", 32'(bus.irq), 0);
        check("t5_pend_kept", 32'(bus.pending), 32'h0000_0002);
        tick();
        check("t5_gap_irq", 32'(bus.irq), 0);
        tick();
        check("t5_regrant_irq", 32'(bus.irq), 1);
        check("t5_regrant_id", 32'(bus.irq_id), 1);
        check("t5_regrant_pend", 32'(bus.pending), 0);

        // 6: asynchronous reset in the middle of SERVICE
        bus.req = 4'b0110;
        tick();
        bus.req = '0;
        check("t6_pend", 32'(bus.pending), 32'h0000_0006);
        check("t6_irq", 32'(bus.irq), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_irq", 32'(bus.irq), 0);
        check("t6_async_ack", 32'(bus.ack), 0);
        check("t6_async_pend", 32'(bus.pending), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_quiet%0d", i), 32'(bus.irq), 0);
        end
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        tick();
        check("t6_new_irq", 32'(bus.irq), 1);
        check("t6_new_id", 32'(bus.irq_id), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_rr.md
Name: irq_ctrl_rr

Overview:
Parametrised interrupt controller and successor to the 4-source fixed-priority controller. It latches requests from NUM_SRC sources into a sticky pending register and filters them through a per-source enable mask. It grants one source at a time using fixed or round-robin priority, raises irq with a one-hot ack and a binary source ID, and waits for a done handshake. A service timeout releases the grant if done never arrives.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
ID_W, $clog2(NUM_SRC), width of irq_id
TIMEOUT_CYC, 256, SERVICE cycles without done before forced release; 0 disables the timeout
CNT_W, 16, timeout counter width; must satisfy TIMEOUT_CYC < 2**CNT_W

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_SRC  level requests, sampled every clock
mask  in  NUM_SRC  1 = source eligible for grant
rr_mode  in  1  0 = fixed priority (index 0 highest), 1 = round-robin
done  in  1  service-complete strobe, honoured only in SERVICE
ack  out  NUM_SRC  one-hot grant, registered
irq  out  1  interrupt to host, registered
irq_id  out  ID_W  index of granted source, valid while irq=1, registered
pending  out  NUM_SRC  current pending register
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pending=0, ack=0, irq=0, irq_id=0, timeout_err=0, rr_ptr=0, counter=0. All outputs return to these values immediately, including mid-SERVICE.
- Pending register: every edge, pending <= (pending & ~clr) | req. clr is the one-hot of the winner on a grant edge, otherwise 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the source stays pending.
  - Masked sources stay pending and become eligible once unmasked.
- eligible = pending & mask.
- Winner selection:
  - Fixed mode: lowest eligible index.
  - Round-robin mode: first eligible index scanning upward from rr_ptr, wrapping from NUM_SRC-1 to 0.
- States: IDLE, SERVICE, HOLDOFF.
- IDLE:
  - If eligible != 0, then at the edge: ack <= onehot(winner), irq <= 1, irq_id <= winner, clear pending[winner], counter <= 0, go to SERVICE.
  - Otherwise stay in IDLE.
  - done is ignored.
- SERVICE: ack, irq and irq_id are held. Changes to mask, req and rr_mode do not affect the current grant.
  - done=1 at an edge: ack <= 0, irq <= 0, rr_ptr <= (irq_id+1) mod NUM_SRC, go to HOLDOFF.
  - Else if TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1: same release as done, plus timeout_err <= 1 for one cycle.
  - Else counter <= counter+1.
  - done and timeout in the same cycle: done wins and timeout_err stays 0.
- HOLDOFF: one cycle, then go to IDLE unconditionally. irq is therefore low for at least 2 cycles between grants. done is ignored.
- rr_ptr updates only on release (done or timeout), in both modes. It has no effect in fixed mode.
- Latency:
  - req high at edge E0 sets pending; irq=1 after E1 if the source is eligible and the state is IDLE.
  - done sampled at edge Ed drops irq after Ed. The earliest next irq is after Ed+2.
- Width rules: irq_id is zero-extended from the scan index. rr_ptr is ID_W bits; for non-power-of-2 NUM_SRC it wraps explicitly at NUM_SRC-1.
- An illegal state encoding goes to IDLE with outputs cleared.

Decomposition:
- Package irq_ctrl_pkg:
  - state encoding localparams (one-hot, 3 bits: IDLE=001, SERVICE=010, HOLDOFF=100)
  - function onehot_to_idx
- Sub-module rr_arbiter, purely combinational:
  - parameter NUM_SRC
  - inputs: eligible, rr_ptr, rr_mode
  - outputs: winner_idx, winner_oh, any
  - implemented as a double-width masked priority scan
- irq_ctrl_rr contains the FSM, the pending register, rr_ptr and the timeout counter.

Test Plan:
1. NUM_SRC=4, rr_mode=0, mask=1111, req=1010 for 1 cycle -> irq=1, ack=0010, irq_id=1 one edge later, pending=1000. After done: HOLDOFF, then grant of ack=1000, irq_id=3.
2. rr_mode=1, req=1111 held, done issued 2 cycles after each grant -> irq_id sequence 0,1,2,3,0. Each grant is preceded by an irq-low gap of at least 2 cycles.
3. mask=0000, req=0100 pulse -> no irq, pending=0100. Then mask=0100 -> irq_id=2 on the next edge.
4. TIMEOUT_CYC=8, grant with no done -> release after exactly 8 SERVICE cycles, timeout_err high for 1 cycle, irq=0.
5. req[1] held high across its own grant edge -> pending[1] remains 1 (set wins) and source 1 is re-granted after HOLDOFF.
6. reset_n low mid-SERVICE with pending=0110 -> irq, ack and pending all 0 asynchronously. After release, no irq until a new req arrives.
